// File: rtl/icache_pkg.sv
// Shared types and helpers for the instruction-cache read-data path.
// Geometry helpers are functions so each instance can derive its own sizes.
package icache_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    localparam int NWAY_DEF    = 4;
    localparam int LINE_W_DEF  = 512;
    localparam int FETCH_W_DEF = 64;
    localparam int AXI_DW_DEF  = 32;

    // Width of an index over n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Beat that completes fetch word `word` when beats arrive from offset 0.
    function automatic int crit_beat(input int word, input int fetch_w, input int axi_dw);
        return ((word + 1) * fetch_w - 1) / axi_dw;
    endfunction

endpackage

// File: rtl/icache_word_sel.sv
// Hit-side selector: one-hot way mux followed by fetch-word extraction.
// A zero or multi-bit way_hit yields an all-zero word.
module icache_word_sel
    import icache_pkg::*;
#(
    parameter int NWAY    = NWAY_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int FETCH_W = FETCH_W_DEF,
    parameter int WIDX_W  = 3
) (
    input  logic [NWAY-1:0]        way_hit_i,
    input  logic [NWAY*LINE_W-1:0] mem_dout_i,
    input  logic [WIDX_W-1:0]      word_idx_i,
    output logic [FETCH_W-1:0]     word_o
);

    logic [LINE_W-1:0] masked_line [NWAY];
    logic [LINE_W-1:0] sel_line;
    logic              one_hot;

    for (genvar gi = 0; gi < NWAY; gi++) begin : g_way
        assign masked_line[gi] = way_hit_i[gi] ? mem_dout_i[gi*LINE_W +: LINE_W] : '0;
    end

    always_comb begin
        sel_line = '0;
        for (int i = 0; i < NWAY; i++) begin
            sel_line = sel_line | masked_line[i];
        end
        one_hot = (way_hit_i != '0) && ((way_hit_i & (way_hit_i - NWAY'(1))) == '0);
        word_o  = one_hot ? sel_line[word_idx_i*FETCH_W +: FETCH_W] : '0;
    end

endmodule

// File: rtl/icache_rdata_path.sv
// Registered instruction-cache read-data path: hit word select, AXI refill
// line assembly with critical-word forwarding, and the full-line fill pulse.
module icache_rdata_path
    import icache_pkg::*;
#(
    parameter int NWAY    = NWAY_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int FETCH_W = FETCH_W_DEF,
    parameter int AXI_DW  = AXI_DW_DEF
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_hit,
    input  logic [31:0]              req_addr,
    input  logic [NWAY-1:0]          way_hit,
    input  logic [NWAY*LINE_W-1:0]   mem_dout,
    input  logic                     cancel,
    input  logic                     ret_valid,
    input  logic [AXI_DW-1:0]        ret_data,
    input  logic                     ret_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FETCH_W-1:0]       out_data,
    output logic                     out_from_refill,
    output logic                     fill_valid,
    output logic [LINE_W-1:0]        fill_line,
    output logic                     busy
);

    localparam int BEATS  = LINE_W / AXI_DW;
    localparam int WORDS  = LINE_W / FETCH_W;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int FOFF_W = $clog2(FETCH_W / 8);
    localparam int WIDX_W = (WORDS > 1) ? OFF_W - FOFF_W : 1;
    localparam int CNT_W  = idx_w(BEATS);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                drop_q, drop_d;
    logic [WIDX_W-1:0]   widx_q, widx_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                out_valid_q, out_valid_d;
    logic [FETCH_W-1:0]  out_data_q, out_data_d;
    logic                out_from_refill_q, out_from_refill_d;
    logic                fill_valid_q, fill_valid_d;
    logic [LINE_W-1:0]   fill_line_q, fill_line_d;

    logic [WIDX_W-1:0]   req_widx;
    logic [FETCH_W-1:0]  hit_word;
    logic [CNT_W-1:0]    crit_cnt;
    logic                addr_unused;

    // Only the word-offset bits of the address matter here.
    assign addr_unused = ^req_addr;

    if (WORDS > 1) begin : g_widx
        assign req_widx = req_addr[OFF_W-1:FOFF_W];
    end else begin : g_widx_one
        assign req_widx = '0;
    end

    icache_word_sel #(
        .NWAY    (NWAY),
        .LINE_W  (LINE_W),
        .FETCH_W (FETCH_W),
        .WIDX_W  (WIDX_W)
    ) u_word_sel (
        .way_hit_i  (way_hit),
        .mem_dout_i (mem_dout),
        .word_idx_i (req_widx),
        .word_o     (hit_word)
    );

    assign crit_cnt  = CNT_W'(crit_beat(int'(widx_q), FETCH_W, AXI_DW));
    assign req_ready = (state_q == IDLE) && (!out_valid_q || out_ready);

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        drop_d            = drop_q;
        widx_d            = widx_q;
        line_d            = line_q;
        out_valid_d       = out_valid_q && !out_ready;
        out_data_d        = out_data_q;
        out_from_refill_d = out_from_refill_q;
        fill_valid_d      = 1'b0;
        fill_line_d       = fill_line_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready && !cancel) begin
                    if (req_hit) begin
                        out_valid_d       = 1'b1;
                        out_data_d        = hit_word;
                        out_from_refill_d = 1'b0;
                    end else begin
                        widx_d  = req_widx;
                        cnt_d   = '0;
                        drop_d  = 1'b0;
                        state_d = REFILL;
                    end
                end
                if (cancel) begin
                    out_valid_d = 1'b0;
                end
            end
            REFILL: begin
                if (ret_valid) begin
                    line_d[cnt_q*AXI_DW +: AXI_DW] = ret_data;
                    if (cnt_q != CNT_W'(BEATS - 1)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    // line_d already holds this beat, so the word slice is complete.
                    if (cnt_q == crit_cnt && !drop_q && !cancel) begin
                        out_valid_d       = 1'b1;
                        out_data_d        = line_d[widx_q*FETCH_W +: FETCH_W];
                        out_from_refill_d = 1'b1;
                    end
                    if (ret_last) begin
                        fill_valid_d = 1'b1;
                        fill_line_d  = line_d;
                        state_d      = IDLE;
                    end
                end
                if (cancel) begin
                    drop_d      = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            drop_q            <= 1'b0;
            widx_q            <= '0;
            line_q            <= '0;
            out_valid_q       <= 1'b0;
            out_data_q        <= '0;
            out_from_refill_q <= 1'b0;
            fill_valid_q      <= 1'b0;
            fill_line_q       <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            drop_q            <= drop_d;
            widx_q            <= widx_d;
            line_q            <= line_d;
            out_valid_q       <= out_valid_d;
            out_data_q        <= out_data_d;
            out_from_refill_q <= out_from_refill_d;
            fill_valid_q      <= fill_valid_d;
            fill_line_q       <= fill_line_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_from_refill = out_from_refill_q;
    assign fill_valid      = fill_valid_q;
    assign fill_line       = fill_line_q;
    assign busy            = (state_q == REFILL);

endmodule

// File: tb/tb_icache_rdata_path.sv
// Directed bench for icache_rdata_path: default geometry plus a
// NWAY=2 / FETCH_W=32 / AXI_DW=64 instance for the wide-beat slice case.
module tb_icache_rdata_path;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          req_valid, req_hit, cancel, ret_valid, ret_last, out_ready;
    logic [31:0]   req_addr;
    logic [3:0]    way_hit;
    logic [2047:0] mem_dout;
    logic [31:0]   ret_data;
    logic          req_ready, out_valid, out_from_refill, fill_valid, busy;
    logic [63:0]   out_data;
    logic [511:0]  fill_line;

    logic          b_req_valid, b_req_hit, b_cancel, b_ret_valid, b_ret_last, b_out_ready;
    logic [31:0]   b_req_addr;
    logic [1:0]    b_way_hit;
    logic [1023:0] b_mem_dout;
    logic [63:0]   b_ret_data;
    logic          b_req_ready, b_out_valid, b_out_from_refill, b_fill_valid, b_busy;
    logic [31:0]   b_out_data;
    logic [511:0]  b_fill_line;

    logic [511:0]  exp_line;
    int            n_checks = 0;
    int            n_fail   = 0;

    icache_rdata_path #(.NWAY(4), .LINE_W(512), .FETCH_W(64), .AXI_DW(32)) dut_a (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_hit(req_hit),
        .req_addr(req_addr), .way_hit(way_hit), .mem_dout(mem_dout), .cancel(cancel),
        .ret_valid(ret_valid), .ret_data(ret_data), .ret_last(ret_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_from_refill(out_from_refill), .fill_valid(fill_valid),
        .fill_line(fill_line), .busy(busy)
    );

    icache_rdata_path #(.NWAY(2), .LINE_W(512), .FETCH_W(32), .AXI_DW(64)) dut_b (
        .clk(clk), .rstn(rstn),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_hit(b_req_hit),
        .req_addr(b_req_addr), .way_hit(b_way_hit), .mem_dout(b_mem_dout), .cancel(b_cancel),
        .ret_valid(b_ret_valid), .ret_data(b_ret_data), .ret_last(b_ret_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_from_refill(b_out_from_refill), .fill_valid(b_fill_valid),
        .fill_line(b_fill_line), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        req_valid = 1'b0; req_hit = 1'b0; req_addr = '0; way_hit = '0; mem_dout = '0;
        cancel = 1'b0; ret_valid = 1'b0; ret_data = '0; ret_last = 1'b0; out_ready = 1'b1;
        b_req_valid = 1'b0; b_req_hit = 1'b0; b_req_addr = '0; b_way_hit = '0; b_mem_dout = '0;
        b_cancel = 1'b0; b_ret_valid = 1'b0; b_ret_data = '0; b_ret_last = 1'b0; b_out_ready = 1'b1;
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < 8; k++)
                mem_dout[w*512 + k*64 +: 64] = 64'(32'h1000 * w + k);
        mem_dout[2*512 + 5*64 +: 64] = 64'hDEAD_BEEF_0123_4567;

        tick(); tick();
        check("rst_out_valid", 512'(out_valid), 512'(0));
        check("rst_out_data", 512'(out_data), 512'(0));
        check("rst_from_refill", 512'(out_from_refill), 512'(0));
        check("rst_fill_valid", 512'(fill_valid), 512'(0));
        check("rst_fill_line", fill_line, 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_req_ready", 512'(req_ready), 512'(1));
        rstn = 1'b1;
        tick();

        // Hit: way 2, word 5
        req_valid = 1'b1; req_hit = 1'b1; way_hit = 4'b0100; req_addr = 32'h0000_1028;
        tick();
        req_valid = 1'b0;
        check("hit_valid", 512'(out_valid), 512'(1));
        check("hit_data", 512'(out_data), 512'(64'hDEAD_BEEF_0123_4567));
        check("hit_from_refill", 512'(out_from_refill), 512'(0));
        tick();
        check("hit_handshake_clear", 512'(out_valid), 512'(0));

        // Backpressure: way 1, word 2
        out_ready = 1'b0;
        req_valid = 1'b1; way_hit = 4'b0010; req_addr = 32'h0000_0010;
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("bp_valid", 512'(out_valid), 512'(1));
            check("bp_data", 512'(out_data), 512'(64'h1002));
            check("bp_req_ready", 512'(req_ready), 512'(0));
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_release", 512'(req_ready), 512'(1));
        tick();
        check("bp_after_handshake", 512'(out_valid), 512'(0));

        // Miss on word 3, beats carry their own index
        req_valid = 1'b1; req_hit = 1'b0; req_addr = 32'h0000_0018;
        tick();
        req_valid = 1'b0;
        check("miss_busy", 512'(busy), 512'(1));
        check("miss_req_ready", 512'(req_ready), 512'(0));
        for (int i = 0; i < 16; i++) begin
            ret_valid = 1'b1; ret_data = 32'(i); ret_last = (i == 15);
            tick();
            if (i == 6) check("miss_no_early_fwd", 512'(out_valid), 512'(0));
            if (i == 7) begin
                check("miss_fwd_valid", 512'(out_valid), 512'(1));
                check("miss_fwd_data", 512'(out_data), 512'(64'h0000_0007_0000_0006));
                check("miss_fwd_from_refill", 512'(out_from_refill), 512'(1));
            end
            if (i == 14) check("miss_fill_not_yet", 512'(fill_valid), 512'(0));
        end
        ret_valid = 1'b0; ret_last = 1'b0;
        for (int k = 0; k < 16; k++) exp_line[k*32 +: 32] = 32'(k);
        check("miss_fill_valid", 512'(fill_valid), 512'(1));
        check("miss_fill_line", fill_line, exp_line);
        check("miss_busy_fall", 512'(busy), 512'(0));
        tick();
        check("miss_fill_pulse_end", 512'(fill_valid), 512'(0));

        // Miss on word 6, cancelled at beat 4
        req_valid = 1'b1; req_addr = 32'h0000_0030;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ret_valid = 1'b1; ret_data = 32'(32'hA0 + i); ret_last = (i == 15); cancel = (i == 4);
            tick();
            if (i == 13) check("cancel_no_fwd", 512'(out_valid), 512'(0));
            if (i == 14) check("cancel_still_busy", 512'(busy), 512'(1));
        end
        ret_valid = 1'b0; ret_last = 1'b0; cancel = 1'b0;
        for (int k = 0; k < 16; k++) exp_line[k*32 +: 32] = 32'(32'hA0 + k);
        check("cancel_fill_valid", 512'(fill_valid), 512'(1));
        check("cancel_fill_line", fill_line, exp_line);
        check("cancel_busy_fall", 512'(busy), 512'(0));
        check("cancel_out_valid", 512'(out_valid), 512'(0));

        // Degenerate hit with two ways flagged
        req_valid = 1'b1; req_hit = 1'b1; way_hit = 4'b0011; req_addr = 32'h0000_0008;
        tick();
        req_valid = 1'b0;
        check("degen_valid", 512'(out_valid), 512'(1));
        check("degen_data", 512'(out_data), 512'(0));
        tick();

        // Reset asserted at beat 9 of a refill for word 0
        out_ready = 1'b0;
        req_valid = 1'b1; req_hit = 1'b0; req_addr = 32'h0000_0000;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ret_valid = 1'b1; ret_data = 32'(32'h50 + i); ret_last = 1'b0;
            tick();
        end
        check("rstmid_fwd_valid", 512'(out_valid), 512'(1));
        check("rstmid_fwd_data", 512'(out_data), 512'(64'h0000_0051_0000_0050));
        ret_valid = 1'b0;
        rstn = 1'b0;
        #2;
        check("rstmid_busy", 512'(busy), 512'(0));
        check("rstmid_out_valid", 512'(out_valid), 512'(0));
        check("rstmid_fill_line", fill_line, 512'(0));
        tick();
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int i = 9; i < 16; i++) begin
            ret_valid = 1'b1; ret_data = 32'(32'h50 + i); ret_last = (i == 15);
            tick();
        end
        ret_valid = 1'b0; ret_last = 1'b0;
        check("rstmid_no_fill", 512'(fill_valid), 512'(0));
        check("rstmid_idle", 512'(busy), 512'(0));
        check("rstmid_no_out", 512'(out_valid), 512'(0));

        // Wide-beat instance: hit way 1 word 7, then miss on word 5
        b_mem_dout[0*512 + 7*32 +: 32] = 32'h0000_2222;
        b_mem_dout[1*512 + 7*32 +: 32] = 32'h7777_1111;
        b_req_valid = 1'b1; b_req_hit = 1'b1; b_way_hit = 2'b10; b_req_addr = 32'h0000_001C;
        tick();
        b_req_valid = 1'b0;
        check("b_hit_valid", 512'(b_out_valid), 512'(1));
        check("b_hit_data", 512'(b_out_data), 512'(32'h7777_1111));
        tick();
        check("b_req_ready", 512'(b_req_ready), 512'(1));
        b_req_valid = 1'b1; b_req_hit = 1'b0; b_req_addr = 32'h0000_0014;
        tick();
        b_req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b_ret_valid = 1'b1; b_ret_last = (i == 7);
            b_ret_data = {32'(32'hC00 + 2*i + 1), 32'(32'hC00 + 2*i)};
            exp_line[i*64 +: 64] = {32'(32'hC00 + 2*i + 1), 32'(32'hC00 + 2*i)};
            tick();
            if (i == 1) check("b_no_early_fwd", 512'(b_out_valid), 512'(0));
            if (i == 2) begin
                check("b_fwd_valid", 512'(b_out_valid), 512'(1));
                check("b_fwd_data", 512'(b_out_data), 512'(32'h0000_0C05));
                check("b_fwd_from_refill", 512'(b_out_from_refill), 512'(1));
            end
        end
        b_ret_valid = 1'b0; b_ret_last = 1'b0;
        check("b_fill_valid", 512'(b_fill_valid), 512'(1));
        check("b_fill_line", b_fill_line, exp_line);
        check("b_busy_fall", 512'(b_busy), 512'(0));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
